// File: rtl/led_color_sequencer.sv
// led_color_sequencer: steps an active-low RGB LED through a colour table (manual/auto/pause) with PWM dimming
// ports: next_i/mode_i debounced pulses, brightness_i duty, r/g/b_led_n pins, color_idx_o, mode_o, step_o
module led_color_sequencer #(
   parameter int DWELL_CYCLES = 12000000,
   parameter int NUM_COLORS   = 8,
   parameter int PWM_BITS     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                next_i,
   input  logic                mode_i,
   input  logic [PWM_BITS-1:0] brightness_i,
   output logic                r_led_n,
   output logic                g_led_n,
   output logic                b_led_n,
   output logic [2:0]          color_idx_o,
   output logic [1:0]          mode_o,
   output logic                step_o
);
   localparam int DW = $clog2(DWELL_CYCLES);
   // {R,G,B} per index, index 0 in the low bits
   localparam logic [23:0] TBL = 24'b111_101_011_110_001_010_100_000;
   typedef enum logic [1:0] {MANUAL = 2'b00, AUTO = 2'b01, PAUSE = 2'b10} mode_t;
   mode_t               mode_q, mode_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [2:0]          idx_q, idx_d, rgb;
   logic [PWM_BITS-1:0] pwm_q, bright_q;
   logic                expire, adv, pwm_on;
   always_comb begin
      mode_d = MANUAL;
      case (mode_q)
         MANUAL:  mode_d = mode_i ? AUTO : MANUAL;
         AUTO:    mode_d = mode_i ? PAUSE : AUTO;
         PAUSE:   mode_d = mode_i ? MANUAL : PAUSE;
         default: mode_d = MANUAL;
      endcase
      expire  = mode_q == AUTO && dwell_q == DW'(DWELL_CYCLES - 1);
      // a mode pulse swallows a coincident step; expiry and next_i merge into one advance
      adv     = !mode_i && (next_i || expire);
      idx_d   = adv ? (idx_q == 3'(NUM_COLORS - 1) ? 3'd0 : idx_q + 3'd1) : idx_q;
      dwell_d = (mode_d != mode_q || mode_q != AUTO && mode_q != PAUSE || adv) ? '0 :
                mode_q == AUTO ? dwell_q + DW'(1) : dwell_q;
      rgb     = TBL[int'(idx_q) * 3 +: 3];
      pwm_on  = pwm_q < bright_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= MANUAL;
         dwell_q  <= '0;
         idx_q    <= '0;
         pwm_q    <= '0;
         bright_q <= '0;
         step_o   <= 1'b0;
         r_led_n  <= 1'b1;
         g_led_n  <= 1'b1;
         b_led_n  <= 1'b1;
      end else begin
         mode_q   <= mode_d;
         dwell_q  <= dwell_d;
         idx_q    <= idx_d;
         pwm_q    <= pwm_q + PWM_BITS'(1);
         bright_q <= pwm_q == '0 ? brightness_i : bright_q;
         step_o   <= adv;
         r_led_n  <= ~(rgb[2] & pwm_on);
         g_led_n  <= ~(rgb[1] & pwm_on);
         b_led_n  <= ~(rgb[0] & pwm_on);
      end
   end
   assign color_idx_o = idx_q;
   assign mode_o      = mode_q;
endmodule
